// File: rtl/spi_word_target.sv
// SPI mode-0 target for 8-bit command / 16-bit address / 16-bit data frames,
// bridged to a single-cycle word-memory port. SPI pins are oversampled on clk.
module spi_word_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] CMD_PREFIX  = 7'b0000001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_cs_n,
  input  logic        spi_clk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  output logic        busy,
  output logic        cmd_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_RFETCH = 3'd3;
  localparam logic [2:0] S_RDATA  = 3'd4;
  localparam logic [2:0] S_WDATA  = 3'd5;
  localparam logic [2:0] S_IGNORE = 3'd6;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d, sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d, fill_q, fill_d;
  logic        cs_n_d_q, sclk_d_q, armed_q, armed_d;
  logic [2:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] shreg_q, shreg_d, addr_q, addr_d, wdata_q, wdata_d;
  logic        rnw_q, rnw_d, miso_q, miso_d, rd_q, rd_d, wr_q, wr_d, err_q, err_d;
  logic        cs_n, sclk, mosi, rise, fall, cs_start, cs_end;

  assign cs_n = cs_sync_q[SYNC_STAGES-1];
  assign sclk = sclk_sync_q[SYNC_STAGES-1];
  assign mosi = mosi_sync_q[SYNC_STAGES-1];

  assign rise     = sclk & ~sclk_d_q;
  assign fall     = ~sclk & sclk_d_q;
  assign cs_start = armed_q & cs_n_d_q & ~cs_n;
  assign cs_end   = ~cs_n_d_q & cs_n;

  // fill marks when the synchroniser holds real pin samples rather than reset
  // values; a frame may only start after CS has genuinely been seen high.
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    armed_d     = armed_q | (fill_q[SYNC_STAGES-1] & cs_n);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rnw_d   = rnw_q;
    miso_d  = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (cs_start) begin
        state_d = S_CMD;
        cnt_d   = '0;
      end
      S_CMD: if (rise) begin
        shreg_d = {shreg_q[14:0], mosi};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd7) begin
          cnt_d = '0;
          if (shreg_q[6:0] == CMD_PREFIX) begin
            rnw_d   = mosi;
            state_d = S_ADDR;
          end else begin
            err_d   = 1'b1;
            state_d = S_IGNORE;
          end
        end
      end
      S_ADDR: if (rise) begin
        addr_d[cnt_q[3:0]] = mosi;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          cnt_d   = '0;
          state_d = rnw_q ? S_RFETCH : S_WDATA;
          rd_d    = rnw_q;
        end
      end
      // cnt 0: strobe cycle; cnt 1: memory data is valid
      S_RFETCH: if (cnt_q == 5'd0) begin
        cnt_d = 5'd1;
      end else begin
        shreg_d = mem_rdata;
        cnt_d   = '0;
        state_d = S_RDATA;
      end
      S_RDATA: begin
        miso_d = miso_q;
        if (fall) begin
          miso_d  = shreg_q[0];
          shreg_d = {1'b0, shreg_q[15:1]};
          if (cnt_q != 5'd16) cnt_d = cnt_q + 5'd1;
        end
      end
      S_WDATA: if (cnt_q == 5'd16) begin
        cnt_d   = '0;
        state_d = S_IGNORE;
      end else if (rise) begin
        shreg_d = {mosi, shreg_q[15:1]};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          wdata_d = {mosi, shreg_q[15:1]};
          wr_d    = 1'b1;
        end
      end
      S_IGNORE: ;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (cs_end) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      miso_d  = 1'b0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      armed_q     <= 1'b0;
      cs_n_d_q    <= 1'b1;
      sclk_d_q    <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rnw_q       <= 1'b0;
      miso_q      <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      fill_q      <= fill_d;
      armed_q     <= armed_d;
      cs_n_d_q    <= cs_n;
      sclk_d_q    <= sclk;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rnw_q       <= rnw_d;
      miso_q      <= miso_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
    end
  end

  assign spi_miso  = miso_q;
  assign mem_addr  = addr_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;
  assign mem_wdata = wdata_q;
  assign cmd_err   = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_word_target.sv
// Scoreboard bench for spi_word_target: SPI controller model plus a one-cycle
// memory responder; expected strobes and MISO bits are queued per frame.
module tb_spi_word_target;
  logic        clk = 1'b0, rst = 1'b1;
  logic        spi_cs_n = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0;
  logic        spi_miso, mem_rd, mem_wr, busy, cmd_err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = 16'h0, rd_word = 16'h0;

  always #5 clk = ~clk;

  spi_word_target #(.SYNC_STAGES(2), .CMD_PREFIX(7'b0000001)) dut (
    .clk(clk), .rst(rst), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .busy(busy), .cmd_err(cmd_err)
  );

  // data only valid the cycle after a read strobe, zero otherwise
  always @(posedge clk) mem_rdata <= mem_rd ? rd_word : 16'h0000;

  int n_vec = 0, n_err = 0, exp_err = 0;
  logic [31:0] exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  logic        exp_miso_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (mem_rd && mem_wr) chk("rd_wr_overlap", 32'd1, 32'd0);
    if (mem_wr) begin
      chk("wr_expected", exp_wr_q.size() > 0, 1);
      if (exp_wr_q.size() > 0) chk("wr_addr_data", {mem_addr, mem_wdata}, exp_wr_q.pop_front());
    end
    if (mem_rd) begin
      chk("rd_expected", exp_rd_q.size() > 0, 1);
      if (exp_rd_q.size() > 0) chk("rd_addr", {16'h0, mem_addr}, {16'h0, exp_rd_q.pop_front()});
    end
    if (cmd_err) begin
      chk("cmd_err_expected", exp_err > 0, 1);
      if (exp_err > 0) exp_err--;
    end
  end

  task automatic spi_bit(input logic b, input string tag, input logic want);
    spi_mosi = b;
    repeat (8) @(negedge clk);
    chk(tag, spi_miso, want);
    spi_clk = 1'b1;
    repeat (8) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [15:0] wd,
                       input int ndata, input int nextra, input int rst_at);
    logic ok, is_rd, e, b;
    ok    = (cmd[7:1] == 7'b0000001);
    is_rd = ok & cmd[0];
    if (is_rd) begin
      exp_rd_q.push_back(addr);
      for (int i = 0; i < 16; i++) exp_miso_q.push_back(rd_word[i]);
    end
    if (ok && !is_rd && ndata >= 16) exp_wr_q.push_back({addr, wd});
    if (!ok) exp_err++;
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 7; i >= 0; i--) spi_bit(cmd[i], "miso_cmd", 1'b0);
    chk("busy_mid", busy, 1);
    for (int i = 0; i < 16; i++) spi_bit(addr[i], "miso_addr", 1'b0);
    for (int i = 0; i < ndata + nextra; i++) begin
      if (i == rst_at) begin
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_miso", spi_miso, 0);
        exp_miso_q.delete();
      end
      e = (exp_miso_q.size() > 0) ? exp_miso_q.pop_front() : 1'b0;
      b = (i < 16 && !is_rd) ? wd[i] : 1'b1;
      spi_bit(b, "miso_data", e);
    end
    if (rst_at >= 0) chk("post_rst_busy", busy, 0);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("miso_after_cs", spi_miso, 0);
    chk("busy_after_cs", busy, 0);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy0", busy, 0);
    chk("rst_miso0", spi_miso, 0);
    chk("rst_strobes0", {mem_rd, mem_wr, cmd_err}, 0);
    chk("rst_addr0", mem_addr, 0);
    chk("rst_wdata0", mem_wdata, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    frame(8'h02, 16'h1234, 16'hBEEF, 16, 0, -1);
    chk("addr_hold", mem_addr, 16'h1234);
    chk("wdata_hold", mem_wdata, 16'hBEEF);

    rd_word = 16'hA5C3;
    frame(8'h03, 16'h0010, 16'h0, 16, 0, -1);

    frame(8'h0B, 16'h5555, 16'h1234, 16, 0, -1);

    frame(8'h02, 16'h0100, 16'hCAFE, 10, 0, -1);
    rd_word = 16'h1357;
    frame(8'h03, 16'h0001, 16'h0, 16, 0, -1);

    frame(8'h02, 16'h0002, 16'h00FF, 16, 8, -1);
    chk("wdata_overclk", mem_wdata, 16'h00FF);

    rd_word = 16'h6E29;
    frame(8'h03, 16'h0040, 16'h0, 16, 0, 5);
    rd_word = 16'h9AB4;
    frame(8'h03, 16'h7FFE, 16'h0, 16, 2, -1);

    chk("wr_queue_empty", exp_wr_q.size(), 0);
    chk("rd_queue_empty", exp_rd_q.size(), 0);
    chk("cmd_err_seen", exp_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL timeout: bench did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_word_target.md
Name: spi_word_target

Overview:
- SPI responder for the M0 bus. It is the target end of the 16-bit address / 16-bit data frame that the M0 SPI controller issues.
- It decodes one read or write frame per chip-select assertion and bridges it to a simple synchronous word-memory port.
- Uses: FPGA emulation of the external RAM/ROM, and as the memory model in system benches.
- Runs on its own oversampling clock. The SPI pins are treated as asynchronous inputs.

Parameters:
- SYNC_STAGES, 2, number of flops in each synchroniser on spi_cs_n, spi_clk and spi_mosi (minimum 2).
- CMD_PREFIX, 7'b0000001, required upper 7 command bits; the 8th bit is R/nW.

Ports:
- clk  input  1  target clock; must be at least 8x the SPI clock frequency.
- rst  input  1  synchronous reset, active high.
- spi_cs_n  input  1  chip select, active low; one instance is tied to CS0 or CS1.
- spi_clk  input  1  SPI clock, mode 0 (idle low, sample on rise).
- spi_mosi  input  1  controller-to-target data.
- spi_miso  output  1  target-to-controller data.
- mem_addr  output  16  word address, held from address completion until the next frame start.
- mem_rd  output  1  one-clk read strobe.
- mem_rdata  input  16  read data, valid exactly 1 clk after mem_rd.
- mem_wr  output  1  one-clk write strobe.
- mem_wdata  output  16  write data, valid while mem_wr is high; held afterwards.
- busy  output  1  high while a frame is in progress (state other than IDLE).
- cmd_err  output  1  one-clk pulse when the command byte does not match CMD_PREFIX.

Behaviour:
- Clock and reset:
  - Single clock domain clk. rst is synchronous and active high.
  - Reset values: spi_miso=0, mem_rd=0, mem_wr=0, cmd_err=0, busy=0, mem_addr=0, mem_wdata=0, state=IDLE, bit counter=0.
  - Synchroniser flops reset to the idle level: cs_n=1, sclk=0, mosi=0.
- Edge detection (all on synchronised signals):
  - rise = sclk & !sclk_d; fall = !sclk & sclk_d.
  - cs_start = cs_n_d & !cs_n; cs_end = !cs_n_d & cs_n.
- cs_end priority:
  - From any state, cs_end moves the FSM to IDLE and forces spi_miso=0 on the same clk.
  - cs_end beats a coincident rise/fall.
  - A write whose 16 data bits are incomplete is discarded: no mem_wr.
- FSM states: IDLE, CMD, ADDR, RFETCH, RDATA, WDATA, IGNORE.
- IDLE:
  - cs_start -> CMD, with bit counter cleared.
  - Edges while CS is high are ignored.
- CMD:
  - Shift mosi MSB-first on each rise; 8 bits total.
  - After the 8th bit: if the upper 7 bits equal CMD_PREFIX, latch rnw = bit0 and go to ADDR.
  - Otherwise pulse cmd_err for 1 clk and go to IGNORE.
- ADDR:
  - 16 bits, LSB-first: the k-th rise supplies mem_addr[k].
  - mem_addr updates in place; the controller always sends bit15=0.
  - After the 16th rise: rnw=1 -> RFETCH; rnw=0 -> WDATA.
- RFETCH:
  - mem_rd=1 for exactly one clk, the clk after entry.
  - On the next clk, load mem_rdata into a 16-bit shift register and go to RDATA.
  - This is 2 clks after the last address rise. With the 8x clock ratio it always precedes the following fall.
- RDATA:
  - On each fall: spi_miso <= shreg[0] and shreg shifts right.
  - The first fall after the address phase drives bit0, so 16 falls deliver the word LSB-first.
  - After 16 falls, further falls drive 0 until cs_end.
- WDATA:
  - Shift mosi LSB-first on each rise.
  - On the 16th rise, mem_wdata <= the assembled word on the same clk, then mem_wr=1 for exactly one clk, then go to IGNORE.
- IGNORE:
  - spi_miso held at 0; extra SPI clocks have no effect.
  - Exactly one memory access per frame.
- spi_miso is 0 in every state except RDATA.
- mem_rd and mem_wr are never asserted together, and never asserted outside RFETCH/WDATA.
- Bit counter is 5 bits and clears on every state transition; it never wraps within a state.
- Reset mid-frame:
  - Returns to IDLE immediately. No pending strobe is issued.
  - If CS is still low after reset, the remainder of that frame is ignored; the synchronised cs_n_d=1 after reset must not fake a cs_start. Only a fresh high-to-low CS edge starts a frame.

Test Plan:
- Write frame: cmd 0x02, addr 0x1234, data 0xBEEF -> exactly one mem_wr pulse with mem_addr=0x1234, mem_wdata=0xBEEF; no mem_rd; spi_miso stays 0.
- Read frame: cmd 0x03, addr 0x0010, mem_rdata=0xA5C3 -> one mem_rd with mem_addr=0x0010; spi_miso on successive falls = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; spi_miso=0 after cs_end.
- Bad command: cmd 0x0B -> cmd_err pulses once after the 8th bit; no mem_rd/mem_wr for the rest of the frame; spi_miso=0.
- Abort: write frame with CS raised after 10 data bits -> no mem_wr; busy falls. A following read of 0x0001 then completes correctly.
- Over-clocking: write 0x00FF to 0x0002 followed by 8 extra SPI clocks before CS rises -> a single mem_wr only.
- Reset mid-read: assert rst during RDATA bit 5 with CS held low -> spi_miso=0 and busy=0 next clk; no activity until a new CS edge; the next read frame returns the correct data.
